// File: rtl/sys_bus.sv
// sys_bus: memory and I/O responder for the 6502 processor bus.
//
// Decodes the core's address every cycle. Read data is purely combinational
// and has no side effects, because the core presents speculative addresses.
// Writes commit on the rising clock edge.
//
// Map: RAM 0x0000..2^RAM_AW-1, I/O page 0xD000..0xD00F, vectors 0xFFFA..0xFFFF.
// Every other address reads 0x00 and ignores writes.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   address    bus address from the core
//   wr_data    write data
//   wr_enable  write strobe
//   rd_data    combinational read data for the current address
//   tx_data    transmit FIFO head byte (0x00 while the FIFO is empty)
//   tx_valid   FIFO non-empty
//   tx_ready   downstream accepts tx_data this cycle
//   irq        timer interrupt pending (level)
module sys_bus #(
    parameter int          RAM_AW       = 11,
    parameter logic [15:0] RESET_VECTOR = 16'h0200,
    parameter logic [15:0] IRQ_VECTOR   = 16'h0300
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [7:0]  wr_data,
    input  logic        wr_enable,
    output logic [7:0]  rd_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);

    logic [7:0]  ram_q [0:(1<<RAM_AW)-1];
    logic [7:0]  fifo_q [0:3];

    logic [1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic        irq_q, irq_d;
    logic        en_q, en_d, auto_q, auto_d;
    logic [15:0] count_q, count_d, reload_q, reload_d;
    logic [7:0]  lo_q, lo_d;

    logic ram_sel, io_sel;
    logic wr_tx, wr_status, wr_lo, wr_hi, wr_ctrl;
    logic empty, full, pop, push, irq_set;

    assign ram_sel = (address[15:RAM_AW] == '0);
    assign io_sel  = (address[15:4] == 12'hD00);

    assign wr_tx     = wr_enable && io_sel && (address[3:0] == 4'h0);
    assign wr_status = wr_enable && io_sel && (address[3:0] == 4'h1);
    assign wr_lo     = wr_enable && io_sel && (address[3:0] == 4'h2);
    assign wr_hi     = wr_enable && io_sel && (address[3:0] == 4'h3);
    assign wr_ctrl   = wr_enable && io_sel && (address[3:0] == 4'h4);

    assign empty = (cnt_q == 3'd0);
    assign full  = (cnt_q == 3'd4);
    assign pop   = !empty && tx_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push  = wr_tx && (!full || pop);

    always_comb begin
        wptr_d   = wptr_q + 2'(push);
        rptr_d   = rptr_q + 2'(pop);
        cnt_d    = cnt_q + 3'(push) - 3'(pop);
        ovf_d    = ovf_q;
        en_d     = en_q;
        auto_d   = auto_q;
        count_d  = count_q;
        reload_d = reload_q;
        lo_d     = lo_q;
        irq_set  = 1'b0;

        if (wr_tx && full && !pop) begin
            ovf_d = 1'b1;
        end else if (wr_status && wr_data[7]) begin
            ovf_d = 1'b0;
        end

        if (en_q) begin
            if (count_q == 16'd0) begin
                irq_set = 1'b1;
                if (auto_q) count_d = reload_q;
                else        en_d    = 1'b0;
            end else begin
                count_d = count_q - 16'd1;
            end
        end

        // Bus writes are applied after the timer step so they take priority.
        if (wr_lo) lo_d = wr_data;
        if (wr_hi) begin
            reload_d = {wr_data, lo_q};
            count_d  = {wr_data, lo_q};
        end
        if (wr_ctrl) begin
            en_d   = wr_data[0];
            auto_d = wr_data[1];
        end

        // Expiry wins over a same-cycle software clear.
        irq_d = irq_set || (irq_q && !(wr_status && wr_data[2]));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q   <= 2'd0;
            rptr_q   <= 2'd0;
            cnt_q    <= 3'd0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
            en_q     <= 1'b0;
            auto_q   <= 1'b0;
            count_q  <= 16'd0;
            reload_q <= 16'd0;
            lo_q     <= 8'd0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
            en_q     <= en_d;
            auto_q   <= auto_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            lo_q     <= lo_d;
        end
    end

    // Storage arrays carry no reset: RAM keeps its contents, and stale FIFO
    // entries are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (wr_enable && ram_sel) ram_q[address[RAM_AW-1:0]] <= wr_data;
        if (push && !reset)       fifo_q[wptr_q] <= wr_data;
    end

    always_comb begin
        rd_data = 8'h00;
        if (ram_sel) begin
            rd_data = ram_q[address[RAM_AW-1:0]];
        end else if (io_sel) begin
            case (address[3:0])
                4'h1:    rd_data = {ovf_q, 4'b0000, irq_q, empty, full};
                4'h2:    rd_data = lo_q;
                4'h3:    rd_data = reload_q[15:8];
                4'h4:    rd_data = {6'b000000, auto_q, en_q};
                4'h5:    rd_data = count_q[7:0];
                4'h6:    rd_data = count_q[15:8];
                default: rd_data = 8'h00;
            endcase
        end else begin
            case (address)
                16'hFFFA: rd_data = IRQ_VECTOR[7:0];
                16'hFFFB: rd_data = IRQ_VECTOR[15:8];
                16'hFFFC: rd_data = RESET_VECTOR[7:0];
                16'hFFFD: rd_data = RESET_VECTOR[15:8];
                16'hFFFE: rd_data = IRQ_VECTOR[7:0];
                16'hFFFF: rd_data = IRQ_VECTOR[15:8];
                default:  rd_data = 8'h00;
            endcase
        end
    end

    assign tx_valid = !empty;
    assign tx_data  = empty ? 8'h00 : fifo_q[rptr_q];
    assign irq      = irq_q;

endmodule
